// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory responder.
//   state_e    - responder FSM states (idle, latency count, response, hold)
//   LatencyMin - smallest legal LATENCY parameter value
//   LatencyMax - largest legal LATENCY parameter value
//   CntWidth   - width of the latency down-counter (holds LatencyMax - 1)
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2,
        StHold = 2'd3
    } state_e;

    localparam int unsigned LatencyMin = 1;
    localparam int unsigned LatencyMax = 15;
    localparam int unsigned CntWidth   = 4;

endpackage

// File: rtl/mem_array.sv
// mem_array: MEM_DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read.
// No reset; contents survive reset of the surrounding logic.
//   clk_i   - clock
//   we_i    - write enable (caller guarantees waddr_i is in range)
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address (caller masks out-of-range results)
//   rdata_o - read data
module mem_array #(
    parameter int unsigned MEM_DEPTH  = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory target on a shared tristate data bus.
// A request is accepted in idle, answered LATENCY+1 cycles later with a one-cycle
// data_valid pulse, and read data stays on the bus until the initiator drops
// req_valid. Dropping req_valid during the latency wait abandons the request.
// Optional feature: define MEM_RESP_ERR_EN to add resp_err.
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset
//   Addr       - request word address
//   Data       - shared bus: write data in, read data out (RESP/HOLD only)
//   we         - 1 = write, 0 = read
//   req_valid  - request strobe, held until the response is seen
//   data_valid - one-cycle response/acknowledge pulse
//   resp_err   - (MEM_RESP_ERR_EN only) pulses with data_valid for out-of-range addresses
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(MEM_DEPTH)-1:0]  Addr,
    inout  wire  [DATA_WIDTH-1:0]         Data,
    input  logic                          we,
    input  logic                          req_valid,
    output logic                          data_valid
`ifdef MEM_RESP_ERR_EN
    ,
    output logic                          resp_err
`endif
);

    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam logic [CntWidth-1:0]   CntLoad  = CntWidth'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0]   DepthLim = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    if (LATENCY < LatencyMin || LATENCY > LatencyMax) begin : g_latency_bad
        $error("mem_responder: LATENCY out of range");
    end

    state_e                state_q;
    logic [CntWidth-1:0]   cnt_q;
    logic                  zero_q;        // counter already sat at 0 for one cycle
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  data_valid_q;
    logic                  drive_q;       // read data on the bus (RESP/HOLD of a read)
`ifdef MEM_RESP_ERR_EN
    logic                  resp_err_q;
`endif

    logic                  in_range;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] rd_data;

    // Addresses past MEM_DEPTH exist only when the depth is not a power of two.
    assign in_range = ({1'b0, addr_q} < DepthLim);
    assign mem_we   = (state_q == StResp) && we_q && in_range;
    assign rd_data  = in_range ? mem_rdata : '0;

    mem_array #(
        .MEM_DEPTH  (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .raddr_i (addr_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            zero_q       <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            data_valid_q <= 1'b0;
            drive_q      <= 1'b0;
`ifdef MEM_RESP_ERR_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            data_valid_q <= 1'b0;
`ifdef MEM_RESP_ERR_EN
            resp_err_q   <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q  <= Addr;
                        we_q    <= we;
                        if (we) begin
                            wdata_q <= Data;
                        end
                        cnt_q   <= CntLoad;
                        zero_q  <= 1'b0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (!req_valid) begin
                        state_q <= StIdle;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!zero_q) begin
                        // Response goes out the cycle after the count reaches 0.
                        zero_q <= 1'b1;
                    end else begin
                        state_q      <= StResp;
                        data_valid_q <= 1'b1;
                        drive_q      <= !we_q;
`ifdef MEM_RESP_ERR_EN
                        resp_err_q   <= !in_range;
`endif
                    end
                end
                StResp: begin
                    state_q <= StHold;
                end
                StHold: begin
                    if (!req_valid) begin
                        state_q <= StIdle;
                        drive_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign Data       = drive_q ? rd_data : {DATA_WIDTH{1'bz}};
    assign data_valid = data_valid_q;
`ifdef MEM_RESP_ERR_EN
    assign resp_err   = resp_err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: drives two responders in lockstep (depth 6 / latency 1 and
// depth 8 / latency 4) with directed and random transactions, checking them
// against a simple array model and the expected response cycle.
module tb_mem_responder;

    localparam int LAT_A   = 1;
    localparam int LAT_B   = 4;
    localparam int DEPTH_A = 6;
    localparam int DEPTH_B = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  addr;
    logic        we;
    logic        req_valid;
    logic        drv_en;
    logic [31:0] drv_data;
    wire  [31:0] data_a;
    wire  [31:0] data_b;
    logic        dv_a;
    logic        dv_b;
`ifdef MEM_RESP_ERR_EN
    logic        err_a;
    logic        err_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_a [8];
    logic [31:0] mem_b [8];

    always #5 clk = ~clk;

    assign data_a = drv_en ? drv_data : {32{1'bz}};
    assign data_b = drv_en ? drv_data : {32{1'bz}};

    mem_responder #(
        .MEM_DEPTH  (DEPTH_A),
        .DATA_WIDTH (32),
        .LATENCY    (LAT_A)
    ) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .Addr       (addr),
        .Data       (data_a),
        .we         (we),
        .req_valid  (req_valid),
        .data_valid (dv_a)
`ifdef MEM_RESP_ERR_EN
        ,
        .resp_err   (err_a)
`endif
    );

    mem_responder #(
        .MEM_DEPTH  (DEPTH_B),
        .DATA_WIDTH (32),
        .LATENCY    (LAT_B)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .Addr       (addr),
        .Data       (data_b),
        .we         (we),
        .req_valid  (req_valid),
        .data_valid (dv_b)
`ifdef MEM_RESP_ERR_EN
        ,
        .resp_err   (err_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_dv_a"}, {31'b0, dv_a}, 32'd0);
        check({tag, "_dv_b"}, {31'b0, dv_b}, 32'd0);
        check({tag, "_data_a"}, data_a, {32{1'bz}});
        check({tag, "_data_b"}, data_b, {32{1'bz}});
    endtask

    // One request starting at a negedge. Acceptance is edge k=1; the response
    // pulse is expected after edge k=LAT+2. With abort set, req_valid drops after k=1.
    task automatic txn(input logic w, input logic [2:0] a, input logic [31:0] d,
                       input bit abort);
        logic [31:0] ea;
        logic [31:0] eb;
        int          last;
        bit          resp_a;
        bit          resp_b;
        ea   = (int'(a) < DEPTH_A) ? mem_a[a] : 32'd0;
        eb   = (int'(a) < DEPTH_B) ? mem_b[a] : 32'd0;
        last = abort ? 1 : LAT_B + 3;
        addr      = a;
        we        = w;
        drv_en    = w;
        drv_data  = d;
        req_valid = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            resp_a = !abort && (k == LAT_A + 2);
            resp_b = !abort && (k == LAT_B + 2);
            check("dv_a", {31'b0, dv_a}, {31'b0, resp_a});
            check("dv_b", {31'b0, dv_b}, {31'b0, resp_b});
            if (!w) begin
                check("rd_a", data_a, (!abort && k >= LAT_A + 2) ? ea : {32{1'bz}});
                check("rd_b", data_b, (!abort && k >= LAT_B + 2) ? eb : {32{1'bz}});
            end else if (k >= 2) begin
                check("wr_bus_a", data_a, {32{1'bz}});
                check("wr_bus_b", data_b, {32{1'bz}});
            end
`ifdef MEM_RESP_ERR_EN
            check("err_a", {31'b0, err_a}, {31'b0, resp_a && (int'(a) >= DEPTH_A)});
            check("err_b", {31'b0, err_b}, 32'd0);
`endif
            @(negedge clk);
            if (k == 1) drv_en = 1'b0;
        end
        req_valid = 1'b0;
        drv_en    = 1'b0;
        @(posedge clk);
        #1;
        check_idle("release");
        if (w && !abort) begin
            if (int'(a) < DEPTH_A) mem_a[a] = d;
            if (int'(a) < DEPTH_B) mem_b[a] = d;
        end
        @(negedge clk);
    endtask

    // Start a request and assert reset after edge at_k; nothing may be written.
    task automatic reset_mid(input logic w, input logic [2:0] a, input logic [31:0] d,
                             input int at_k);
        addr      = a;
        we        = w;
        drv_en    = w;
        drv_data  = d;
        req_valid = 1'b1;
        for (int k = 1; k <= at_k; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) drv_en = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle("reset_mid");
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic        rw;
        logic [2:0]  ra;
        logic [31:0] rd;
        bit          rab;

        for (int i = 0; i < 8; i++) begin
            mem_a[i] = 32'd0;
            mem_b[i] = 32'd0;
        end
        reset     = 1'b1;
        addr      = 3'd0;
        we        = 1'b0;
        req_valid = 1'b0;
        drv_en    = 1'b0;
        drv_data  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
`ifdef MEM_RESP_ERR_EN
        check("reset_err_a", {31'b0, err_a}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Give every word a known value.
        for (int i = 0; i < 8; i++) txn(1'b1, 3'(i), $urandom, 1'b0);

        // Write then read, then back-to-back read of address 4.
        txn(1'b1, 3'd3, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 3'd3, 32'd0, 1'b0);
        txn(1'b0, 3'd4, 32'd0, 1'b0);

        // Abandoned write leaves the old value.
        txn(1'b1, 3'd2, 32'h1, 1'b1);
        txn(1'b0, 3'd2, 32'd0, 1'b0);

        // Out-of-range on the depth-6 responder.
        txn(1'b0, 3'd7, 32'd0, 1'b0);
        txn(1'b1, 3'd6, 32'hA5A5A5A5, 1'b0);
        txn(1'b0, 3'd6, 32'd0, 1'b0);
        txn(1'b0, 3'd5, 32'd0, 1'b0);

        // Reset during HOLD of a read, then during BUSY of a write.
        reset_mid(1'b0, 3'd3, 32'd0, LAT_B + 3);
        txn(1'b0, 3'd3, 32'd0, 1'b0);
        reset_mid(1'b1, 3'd1, 32'h12345678, 2);
        txn(1'b0, 3'd1, 32'd0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rw  = 1'($urandom_range(0, 1));
            ra  = 3'($urandom_range(0, 7));
            rd  = $urandom;
            rab = ($urandom_range(0, 5) == 0);
            txn(rw, ra, rd, rab);
        end
        for (int i = 0; i < 8; i++) txn(1'b0, 3'(i), 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_DEPTH, default 8: number of storage words.
REQ-002 Parameter DATA_WIDTH, default 32: word width in bits.
REQ-003 Parameter LATENCY, default 2, legal range 1..15: cycles from request acceptance to data_valid.
REQ-004 Localparam ADDR_WIDTH SHALL equal $clog2(MEM_DEPTH).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 Addr  input  ADDR_WIDTH  request word address.
REQ-008 Data  inout  DATA_WIDTH  shared data bus; driven by the initiator for writes, by this block for read responses.
REQ-009 we  input  1  1 = write request, 0 = read request.
REQ-010 req_valid  input  1  initiator request strobe, held high until a response is received.
REQ-011 data_valid  output  1  one-cycle response or acknowledge pulse.

Function
REQ-012 States SHALL be IDLE, BUSY, RESP and HOLD.
REQ-013 In IDLE with req_valid=1, the block SHALL capture Addr and we, plus Data when we=1, load the latency counter with LATENCY-1, and enter BUSY.
REQ-014 BUSY SHALL decrement the counter each cycle and enter RESP in the cycle after the counter reaches 0, so that data_valid rises exactly LATENCY+1 cycles after the acceptance edge.
REQ-015 If req_valid=0 in any BUSY cycle, the block SHALL abandon the transaction, perform no write, and return to IDLE.
REQ-016 RESP SHALL last one cycle with data_valid=1, then enter HOLD.
REQ-017 For a write, the captured data SHALL be written into the array on the RESP cycle.
REQ-018 For a read, Data SHALL be driven with mem[captured Addr] during RESP and HOLD, and released to high-Z in all other states.
REQ-019 HOLD SHALL keep driving read data with data_valid=0 until a cycle with req_valid=0 is sampled, then return to IDLE.
REQ-020 While in IDLE, the block SHALL accept no new request until req_valid has been seen low for at least one cycle after HOLD.
REQ-021 Requests in BUSY, RESP or HOLD SHALL be ignored; there is no queuing.
REQ-022 An address >= MEM_DEPTH (possible when MEM_DEPTH is not a power of 2) SHALL read as all-zero and SHALL not be written, while still being acknowledged normally.
REQ-023 The Data bus SHALL never be driven while we=1 is captured.

Reset
REQ-024 Reset SHALL force the state to IDLE, data_valid to 0, the Data bus to high-Z, and the counter and captured fields to 0.
REQ-025 Reset asserted mid-transaction SHALL abort it with no write.
REQ-026 Memory contents SHALL be unaffected by reset.

Configuration
REQ-027 Macro MEM_RESP_ERR_EN, when defined, SHALL add output resp_err (1 bit, reset 0), which pulses with data_valid for out-of-range accesses.
REQ-028 When MEM_RESP_ERR_EN is undefined, the port SHALL be absent and the behaviour otherwise identical.

Structure
REQ-029 Shared package mem_pkg SHALL hold the state typedef and encodings, plus the LATENCY range constants.
REQ-030 Storage SHALL be a sub-module mem_array (synchronous write, asynchronous read, MEM_DEPTH x DATA_WIDTH); the FSM, counter and tristate SHALL remain in mem_responder.

Verification
REQ-031 Write then read: write Addr=3, Data=32'hDEADBEEF; release; read Addr=3 -> data_valid one cycle, Data=32'hDEADBEEF in the RESP and following HOLD cycles.
REQ-032 Latency: LATENCY=1 and LATENCY=4, read accepted at edge N -> data_valid high only in the cycle after edge N+LATENCY+1.
REQ-033 Back-to-back: initiator drops req_valid one cycle after data_valid, then reasserts next cycle with Addr=4 -> second request accepted, both responses correct, data_valid never high two consecutive cycles.
REQ-034 Abort: write Addr=2, Data=32'h1, with req_valid dropped in BUSY -> no data_valid; a subsequent read of Addr 2 returns the prior value.
REQ-035 Reset in HOLD during a read -> next cycle Data=Z, data_valid=0, state IDLE; memory preserved.
REQ-036 MEM_DEPTH=6, MEM_RESP_ERR_EN defined: read Addr=7 -> Data=0 and resp_err=1 coincident with data_valid; write to Addr=6 leaves the array unchanged.
